c1355_bist_ctrl: RTL and testbench

C1355_BIST_CTRL -- requirements
Module: c1355_bist_ctrl

---
 rtl/c1355_bist_pkg.sv | 31 +++
 rtl/c1355_sig_core.sv | 57 +++++
 rtl/c1355_bist_ctrl.sv | 145 ++++++++++++++
 tb/tb_c1355_bist_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/c1355_bist_pkg.sv
// Shared types and constants for the c1355 BIST controller.
// Also holds the LFSR/MISR step functions so the register core and any model agree on taps.
package c1355_bist_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StApply,
    StSettle,
    StCapture,
    StDone
  } bist_state_e;

  localparam int unsigned LfsrWidth = 41;
  localparam int unsigned MisrWidth = 32;

  localparam logic [MisrWidth-1:0] MisrPolyDefault = 32'h8020_0003;

  localparam int unsigned LfsrTapHi = 40;
  localparam int unsigned LfsrTapLo = 2;

  function automatic logic [LfsrWidth-1:0] lfsr_next(input logic [LfsrWidth-1:0] v);
    return {v[LfsrWidth-2:0], v[LfsrTapHi] ^ v[LfsrTapLo]};
  endfunction

  function automatic logic [MisrWidth-1:0] misr_next(input logic [MisrWidth-1:0] s,
                                                     input logic [MisrWidth-1:0] poly,
                                                     input logic [MisrWidth-1:0] d);
    return {s[MisrWidth-2:0], 1'b0} ^ (s[MisrWidth-1] ? poly : '0) ^ d;
  endfunction

endpackage

// File: rtl/c1355_sig_core.sv
// Stimulus LFSR and response MISR registers for the c1355 BIST controller.
// The controller only issues load / advance / clear / compact strobes.
module c1355_sig_core
  import c1355_bist_pkg::*;
#(
  parameter logic [LfsrWidth-1:0] LFSR_SEED = 41'h1,
  parameter logic [MisrWidth-1:0] MISR_POLY = MisrPolyDefault
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic                 advance_i,
  input  logic                 clear_i,
  input  logic                 compact_i,
  input  logic [MisrWidth-1:0] resp_i,
  output logic [LfsrWidth-1:0] vec_o,
  output logic [MisrWidth-1:0] signature_o
);

  // An all-zero seed would lock the LFSR up, so it is replaced by 1.
  localparam logic [LfsrWidth-1:0] SeedEff = (LFSR_SEED == '0) ? 41'h1 : LFSR_SEED;

  logic [LfsrWidth-1:0] vec_q, vec_d;
  logic [MisrWidth-1:0] sig_q, sig_d;

  always_comb begin
    vec_d = vec_q;
    if (load_i) begin
      vec_d = SeedEff;
    end else if (advance_i) begin
      vec_d = lfsr_next(vec_q);
    end
  end

  always_comb begin
    sig_d = sig_q;
    if (clear_i) begin
      sig_d = '0;
    end else if (compact_i) begin
      sig_d = misr_next(sig_q, MISR_POLY, resp_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vec_q <= '0;
      sig_q <= '0;
    end else begin
      vec_q <= vec_d;
      sig_q <= sig_d;
    end
  end

  assign vec_o       = vec_q;
  assign signature_o = sig_q;

endmodule

// File: rtl/c1355_bist_ctrl.sv
// BIST sequencer for a c1355 block: applies LFSR vectors, waits a settle time,
// and compacts the responses into a MISR signature.
module c1355_bist_ctrl
  import c1355_bist_pkg::*;
#(
  parameter int unsigned          SETTLE_CYCLES = 2,
  parameter logic [LfsrWidth-1:0] LFSR_SEED     = 41'h1,
  parameter logic [MisrWidth-1:0] MISR_POLY     = MisrPolyDefault
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [15:0]          num_vectors_i,
  input  logic [MisrWidth-1:0] resp_i,
  output logic [LfsrWidth-1:0] vec_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [MisrWidth-1:0] signature_o,
  output logic [15:0]          vec_count_o
);

  // Out-of-range settle times are clamped into 1..15 so the down-counter always terminates.
  localparam int unsigned SettleClamp = (SETTLE_CYCLES < 1)  ? 1  :
                                        (SETTLE_CYCLES > 15) ? 15 : SETTLE_CYCLES;
  localparam logic [3:0]  SettleInit  = 4'(SettleClamp);

  bist_state_e state_q;
  logic [3:0]  settle_q;
  logic [15:0] count_q;
  logic [15:0] num_q;
  logic        busy_q;
  logic        done_q;

  logic        idle_like;
  logic        accept;
  logic        last_vec;
  logic [15:0] count_inc;

  logic        core_load;
  logic        core_advance;
  logic        core_clear;
  logic        core_compact;

  always_comb begin
    idle_like    = (state_q == StIdle) || (state_q == StDone);
    accept       = idle_like && start_i;
    count_inc    = count_q + 16'd1;
    last_vec     = (count_inc == num_q);
    core_load    = accept && (num_vectors_i != 16'd0);
    core_clear   = accept;
    core_compact = (state_q == StCapture);
    // An abort in CAPTURE still compacts but must not move vec.
    core_advance = (state_q == StCapture) && !abort_i && !last_vec;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      settle_q <= '0;
      count_q  <= '0;
      num_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            num_q   <= num_vectors_i;
            count_q <= '0;
            if (num_vectors_i != 16'd0) begin
              state_q <= StApply;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end else begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        StApply: begin
          if (abort_i) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            state_q  <= StSettle;
            settle_q <= SettleInit;
          end
        end
        StSettle: begin
          if (abort_i) begin
            state_q  <= StIdle;
            settle_q <= '0;
            busy_q   <= 1'b0;
          end else if (settle_q <= 4'd1) begin
            state_q  <= StCapture;
            settle_q <= '0;
          end else begin
            settle_q <= settle_q - 4'd1;
          end
        end
        StCapture: begin
          count_q <= count_inc;
          if (abort_i) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (last_vec) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= StApply;
          end
        end
        default: begin
          state_q  <= StIdle;
          settle_q <= '0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  c1355_sig_core #(
    .LFSR_SEED (LFSR_SEED),
    .MISR_POLY (MISR_POLY)
  ) u_sig_core (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (core_load),
    .advance_i   (core_advance),
    .clear_i     (core_clear),
    .compact_i   (core_compact),
    .resp_i      (resp_i),
    .vec_o       (vec_o),
    .signature_o (signature_o)
  );

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign vec_count_o = count_q;

endmodule

// File: tb/tb_c1355_bist_ctrl.sv
// Directed bench for c1355_bist_ctrl with SETTLE_CYCLES=2 and seed 1.
// Expected signatures and vectors are hand-computed.
module tb_c1355_bist_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] num_vectors;
  logic [31:0] resp;
  logic [40:0] vec;
  logic        busy;
  logic        done;
  logic [31:0] signature;
  logic [15:0] vec_count;

  logic        loop_mode;
  logic [31:0] resp_const;

  int checks;
  int errors;

  c1355_bist_ctrl #(
    .SETTLE_CYCLES (2),
    .LFSR_SEED     (41'h1),
    .MISR_POLY     (32'h8020_0003)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .abort_i       (abort),
    .num_vectors_i (num_vectors),
    .resp_i        (resp),
    .vec_o         (vec),
    .busy_o        (busy),
    .done_o        (done),
    .signature_o   (signature),
    .vec_count_o   (vec_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign resp = loop_mode ? vec[31:0] : resp_const;

  typedef struct {
    logic [15:0] num;
    logic        loop;
    logic [31:0] rconst;
    logic [31:0] exp_sig;
    logic [15:0] exp_cnt;
    int          exp_busy;
    logic [40:0] exp_vec;
  } case_t;

  case_t tbl [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issues a single start pulse, then counts busy cycles until done (bounded).
  task automatic run_to_done(input logic [15:0] n, output int busy_cycles, output bit got_done);
    busy_cycles = 0;
    got_done    = 1'b0;
    @(negedge clk);
    start       = 1'b1;
    num_vectors = n;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (busy) busy_cycles++;
      if (done) begin
        got_done = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int  bc;
    bit  gd;
    logic [31:0] sig_snap;

    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    num_vectors = '0;
    loop_mode   = 1'b1;
    resp_const  = '0;

    // {num, loop, rconst, exp_sig, exp_cnt, exp_busy, exp_vec}
    tbl[0] = '{16'd1, 1'b1, 32'h0,         32'h0000_0001, 16'd1, 4,  41'h1};
    tbl[1] = '{16'd2, 1'b1, 32'h0,         32'h0000_0000, 16'd2, 8,  41'h2};
    tbl[2] = '{16'd0, 1'b1, 32'h0,         32'h0000_0000, 16'd0, 0,  41'h2};
    tbl[3] = '{16'd3, 1'b1, 32'h0,         32'h0000_0004, 16'd3, 12, 41'h4};
    tbl[4] = '{16'd4, 1'b1, 32'h0,         32'h0000_0001, 16'd4, 16, 41'h9};
    tbl[5] = '{16'd6, 1'b1, 32'h0,         32'h0000_0004, 16'd6, 24, 41'h24};
    tbl[6] = '{16'd1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'd1, 4,  41'h1};
    tbl[7] = '{16'd2, 1'b0, 32'h8000_0000, 32'h0020_0003, 16'd2, 8,  41'h2};
    tbl[8] = '{16'd3, 1'b0, 32'h8000_0000, 32'h8040_0006, 16'd3, 12, 41'h4};

    repeat (2) @(negedge clk);
    check("reset_vec",   64'(vec), 64'h0);
    check("reset_sig",   64'(signature), 64'h0);
    check("reset_count", 64'(vec_count), 64'h0);
    check("reset_busy",  64'(busy), 64'h0);
    check("reset_done",  64'(done), 64'h0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset_busy", 64'(busy), 64'h0);

    for (int i = 0; i < 9; i++) begin
      loop_mode  = tbl[i].loop;
      resp_const = tbl[i].rconst;
      run_to_done(tbl[i].num, bc, gd);
      check($sformatf("case%0d_done", i),  64'(gd), 64'h1);
      check($sformatf("case%0d_busy_cycles", i), 64'(bc), 64'(tbl[i].exp_busy));
      check($sformatf("case%0d_sig", i),   64'(signature), 64'(tbl[i].exp_sig));
      check($sformatf("case%0d_count", i), 64'(vec_count), 64'(tbl[i].exp_cnt));
      check($sformatf("case%0d_vec", i),   64'(vec), 64'(tbl[i].exp_vec));
      repeat (3) @(negedge clk);
      check($sformatf("case%0d_hold_done", i), 64'(done), 64'h1);
      check($sformatf("case%0d_hold_sig", i),  64'(signature), 64'(tbl[i].exp_sig));
    end

    // Abort in the 3rd SETTLE of a 5-vector run.
    loop_mode = 1'b1;
    @(negedge clk);
    start       = 1'b1;
    num_vectors = 16'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("abort_pre_busy", 64'(busy), 64'h1);
    check("abort_pre_vec",  64'(vec), 64'h4);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy",  64'(busy), 64'h0);
    check("abort_done",  64'(done), 64'h0);
    check("abort_count", 64'(vec_count), 64'd2);
    check("abort_sig",   64'(signature), 64'h0);
    repeat (2) @(negedge clk);
    check("abort_stays_idle", 64'(busy | done), 64'h0);
    @(negedge clk);
    start       = 1'b1;
    num_vectors = 16'd1;
    @(negedge clk);
    start = 1'b0;
    check("restart_vec_seed", 64'(vec), 64'h1);
    check("restart_busy",     64'(busy), 64'h1);
    repeat (4) @(negedge clk);
    check("restart_done", 64'(done), 64'h1);
    check("restart_sig",  64'(signature), 64'h1);

    // Abort coinciding with the final CAPTURE: update happens, no DONE.
    @(negedge clk);
    start       = 1'b1;
    num_vectors = 16'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_cap_done",  64'(done), 64'h0);
    check("abort_cap_busy",  64'(busy), 64'h0);
    check("abort_cap_count", 64'(vec_count), 64'd1);
    check("abort_cap_sig",   64'(signature), 64'h1);

    // Asynchronous reset during CAPTURE of vector 3.
    @(negedge clk);
    start       = 1'b1;
    num_vectors = 16'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    check("rst_pre_count", 64'(vec_count), 64'd2);
    rst = 1'b1;
    #1;
    check("rst_async_vec",   64'(vec), 64'h0);
    check("rst_async_sig",   64'(signature), 64'h0);
    check("rst_async_count", 64'(vec_count), 64'h0);
    check("rst_async_busy",  64'(busy | done), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    gd = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done || busy) gd = 1'b1;
    end
    check("rst_no_activity", 64'(gd), 64'h0);

    // start held high for the whole run is ignored while busy.
    @(negedge clk);
    start       = 1'b1;
    num_vectors = 16'd4;
    bc = 0;
    gd = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 100; k++) begin
      if (busy) bc++;
      if (done) begin
        gd    = 1'b1;
        start = 1'b0;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("hold_start_done",  64'(gd), 64'h1);
    check("hold_start_busy",  64'(bc), 64'd16);
    check("hold_start_sig",   64'(signature), 64'h1);
    check("hold_start_count", 64'(vec_count), 64'd4);
    sig_snap = signature;
    repeat (3) @(negedge clk);
    check("hold_start_stable", 64'(signature), 64'(sig_snap));
    check("hold_start_done_stays", 64'(done), 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
